// File: rtl/rv_fetch_queue.sv
// rv_fetch_queue: instruction-fetch front end with a decoupling FIFO.
// Owns the PC, issues in-order fetch requests and buffers {pc, instr}
// pairs for decode. A redirect flushes the queue and discards all
// responses still in flight from before the redirect.
// Optional feature macro: RV_FQ_BYPASS_EN. When defined, a response that
// arrives while the queue is empty is forwarded to decode in the same cycle.

module rv_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic                       imem_rsp_valid,
  input  logic [31:0]                imem_rsp_data,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [31:0]                id_instr,
  output logic [XLEN-1:0]            id_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  // Headroom above the queue depth: drop is reloaded from inflight, and
  // requests keep issuing while older responses drain.
  localparam int IW = CW + 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_next;

  logic [XLEN-1:0] pc;
  logic [IW-1:0]   inflight;
  logic [IW-1:0]   drop;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [CW-1:0]   count_q;

  // Tags are only kept for requests whose responses will be used; tags of
  // requests outstanding at a redirect are thrown away with the flush.
  logic [XLEN-1:0] tag_mem [DEPTH];
  logic [AW-1:0]   tag_head;
  logic [AW-1:0]   tag_tail;

  logic [IW-1:0]   live;
  logic [IW-1:0]   occupancy;
  logic [IW-1:0]   inflight_ret;
  logic            req_fire;
  logic            rsp_drop;
  logic            rsp_keep;
  logic [XLEN-1:0] rsp_pc;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic            redirect_pc_unused;

  assign redirect_pc_unused = ^redirect_pc[1:0];

  assign live         = inflight - drop;
  assign occupancy    = IW'(count_q) + live;
  assign inflight_ret = inflight - IW'(imem_rsp_valid);

  assign imem_req_valid = (state != BOOT) & !redirect & (occupancy < IW'(DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign rsp_drop   = imem_rsp_valid & ((drop != '0) | redirect);
  assign rsp_keep   = imem_rsp_valid & (drop == '0) & !redirect;
  assign rsp_pc     = tag_mem[tag_head];
  assign fifo_empty = (count_q == '0);
  assign count      = count_q;

`ifdef RV_FQ_BYPASS_EN
  logic bypass;
  assign bypass   = fifo_empty & rsp_keep & (state != BOOT);
  assign id_valid = (!fifo_empty & !redirect) | bypass;
  assign id_instr = bypass ? imem_rsp_data : instr_mem[head];
  assign id_pc    = bypass ? rsp_pc : pc_mem[head];
  assign pop      = id_ready & !fifo_empty & !redirect;
  assign push     = rsp_keep & !(bypass & id_ready);
`else
  assign id_valid = !fifo_empty & !redirect;
  assign id_instr = instr_mem[head];
  assign id_pc    = pc_mem[head];
  assign pop      = id_valid & id_ready;
  assign push     = rsp_keep;
`endif

  // State register for the boot/run/drain sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BOOT;
    else     state <= state_next;
  end

  // Next state: enter DRAIN whenever a redirect leaves responses to discard.
  always_comb begin
    state_next = state;
    case (state)
      BOOT: state_next = RUN;
      RUN: begin
        if (redirect && (inflight_ret != '0)) state_next = DRAIN;
      end
      DRAIN: begin
        if (redirect)                        state_next = (inflight_ret != '0) ? DRAIN : RUN;
        else if (rsp_drop && (drop == IW'(1))) state_next = RUN;
      end
      default: state_next = BOOT;
    endcase
  end

  // PC, outstanding-request and discard counters; redirect wins over all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else if (redirect) begin
      pc       <= {redirect_pc[XLEN-1:2], 2'b00};
      inflight <= inflight_ret;
      drop     <= inflight_ret;
    end else begin
      if (req_fire) pc <= pc + XLEN'(4);
      inflight <= inflight + IW'(req_fire) - IW'(imem_rsp_valid);
      if (rsp_drop) drop <= drop - IW'(1);
    end
  end

  // Tag FIFO: PC of each live request, written at issue, read at response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_head <= '0;
      tag_tail <= '0;
      for (int i = 0; i < DEPTH; i++) tag_mem[i] <= '0;
    end else if (redirect) begin
      tag_head <= '0;
      tag_tail <= '0;
    end else begin
      if (req_fire) begin
        tag_mem[tag_tail] <= pc;
        tag_tail          <= tag_tail + AW'(1);
      end
      if (rsp_keep) tag_head <= tag_head + AW'(1);
    end
  end

  // Instruction queue toward decode; flushed by redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (redirect) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        pc_mem[tail]    <= rsp_pc;
        instr_mem[tail] <= imem_rsp_data;
        tail            <= tail + AW'(1);
      end
      if (pop) head <= head + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
